muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage; sole producer of HI/LO write data.
- Accepts one MULT/MULTU/DIV/DIVU (optionally MADD/MSUB family) operation at a time and runs it to completion.
- Drives a one-cycle write strobe into the HI/LO register file directly downstream; the pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/DIV unit, sole producer of HI/LO writes.
// Define MDU_MADD_EN to also accept the MADD/MSUB accumulate family.
module muldiv_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] whi,
  output logic [31:0] wlo,
  output logic [1:0]  whilo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(DIV_ITER - 1);

  state_t state;
  state_t state_n;

  logic        accept;
  logic        op_ok;
  logic        op_div;
  logic        op_sgn;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] quot_r;
  logic [31:0] rem_r;
  logic [4:0]  cnt;
  logic        qneg;
  logic        rneg;
  logic        divz;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [63:0] res;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Decode the request: divide vs multiply, signedness, support.
  always_comb begin
    op_div = ~op[2] & op[1];
    op_sgn = ~op[0];
`ifdef MDU_MADD_EN
    op_ok  = 1'b1;
`else
    op_ok  = ~op[2];
`endif
    neg_a  = op_sgn & src_a[31];
    neg_b  = op_sgn & src_b[31];
    mag_a  = neg_a ? -src_a : src_a;
    mag_b  = neg_b ? -src_b : src_b;
  end

  // Next-state logic; flush aborts and blocks acceptance.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (op_valid && op_ok) begin
            accept  = 1'b1;
            state_n = op_div ? DIV : MUL;
          end
        end
        MUL: state_n = IDLE;
        DIV: begin
          if (cnt == CNT_LAST) state_n = FIX;
        end
        FIX: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
    end
  end

  // Divide step, product, accumulate and sign fix-up.
  always_comb begin
    rem_sh = {rem_r, quot_r[31]};
    diff   = rem_sh - {1'b0, b_r};
    ext_a  = {{32{~op_r[0] & a_r[31]}}, a_r};
    ext_b  = {{32{~op_r[0] & b_r[31]}}, b_r};
    prod   = ext_a * ext_b;
`ifdef MDU_MADD_EN
    if (!op_r[2]) begin
      res = prod;
    end else if (op_r[1]) begin
      res = {hi_in, lo_in} - prod;
    end else begin
      res = {hi_in, lo_in} + prod;
    end
`else
    res = prod;
`endif
    q_fix  = divz ? 32'hFFFF_FFFF :
             (qneg ? -quot_r : quot_r);
    r_fix  = rneg ? -rem_r : rem_r;
  end

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi_in, lo_in, op_r[2:1]};
`endif

  // Operand latch, iteration and the one-cycle HI/LO write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      whi    <= '0;
      wlo    <= '0;
      whilo  <= 2'b00;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      cnt    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      divz   <= 1'b0;
    end else begin
      whilo <= 2'b00;
      if (accept) begin
        op_r   <= op;
        a_r    <= src_a;
        b_r    <= op_div ? mag_b : src_b;
        quot_r <= op_div ? mag_a : 32'd0;
        rem_r  <= '0;
        cnt    <= '0;
        qneg   <= op_div & (neg_a ^ neg_b);
        rneg   <= op_div & neg_a;
        divz   <= (src_b == 32'd0);
      end else if (!flush) begin
        case (state)
          MUL: begin
            whi   <= res[63:32];
            wlo   <= res[31:0];
            whilo <= 2'b11;
          end
          DIV: begin
            rem_r  <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quot_r <= {quot_r[30:0], ~diff[32]};
            cnt    <= cnt + 5'd1;
          end
          FIX: begin
            whi   <= r_fix;
            wlo   <= q_fix;
            whilo <= 2'b11;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with a
// cycle-level result/latency model checked on every cycle.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        flush;
  logic        busy;
  logic [31:0] whi;
  logic [31:0] wlo;
  logic [1:0]  whilo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk),
    .resetn(resetn),
    .op_valid(op_valid),
    .op(op),
    .src_a(src_a),
    .src_b(src_b),
    .hi_in(hi_in),
    .lo_in(lo_in),
    .flush(flush),
    .busy(busy),
    .whi(whi),
    .wlo(wlo),
    .whilo(whilo)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic bit supp(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return ~o[2];
`endif
  endfunction

  // {hi,lo}: remainder/quotient for divides, product otherwise
  function automatic logic [63:0] calc(input logic [2:0] o,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa;
    longint sb;
    int si;
    int sd;
    logic [31:0] q;
    logic [31:0] r;
    if (o == 3'b010 || o == 3'b011) begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else if (o == 3'b011) begin
        q = a / b;
        r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        si = $signed(a);
        sd = $signed(b);
        q = 32'(si / sd);
        r = 32'(si % sd);
      end
      return {r, q};
    end
    sa = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  bit          m_ok = 1'b0;
  bit          m_in = 1'b0;
  int          m_left;
  logic [2:0]  m_op;
  logic [63:0] m_res;
  logic [63:0] fin;
  logic        e_busy;
  logic [1:0]  e_whilo;
  logic [31:0] e_hi;
  logic [31:0] e_lo;

  // model: what must be visible after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      e_whilo = 2'b00;
      if (!resetn) begin
        m_in = 1'b0;
        e_hi = '0;
        e_lo = '0;
        m_ok = 1'b1;
      end else if (flush) begin
        m_in = 1'b0;
      end else if (m_in) begin
        m_left--;
        if (m_left == 0) begin
          m_in = 1'b0;
          e_whilo = 2'b11;
          if (!m_op[2]) fin = m_res;
          else if (m_op[1]) fin = {hi_in, lo_in} - m_res;
          else fin = {hi_in, lo_in} + m_res;
          e_hi = fin[63:32];
          e_lo = fin[31:0];
        end
      end else if (op_valid && supp(op)) begin
        m_in = 1'b1;
        m_op = op;
        m_left = (op == 3'b010 || op == 3'b011) ? 33 : 1;
        m_res = calc(op, src_a, src_b);
      end
      e_busy = m_in;
    end
  end

  // compare every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("busy", 64'(busy), 64'(e_busy));
        chk("whilo", 64'(whilo), 64'(e_whilo));
        chk("whi", 64'(whi), 64'(e_hi));
        chk("wlo", 64'(wlo), 64'(e_lo));
      end
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // waits for the write; ends at the negedge of the write cycle
  task automatic wait_wr(input string nm, input int lat,
                         input logic [31:0] eh,
                         input logic [31:0] el);
    int n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) chk({nm, " busy1"}, 64'(busy), 64'(1));
      if (whilo == 2'b11) begin
        n = i;
        break;
      end
    end
    chk({nm, " lat"}, 64'(n), 64'(lat));
    chk({nm, " hi"}, 64'(whi), 64'(eh));
    chk({nm, " lo"}, 64'(wlo), 64'(el));
    chk({nm, " idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    op_valid = 1'b0;
    op = '0;
    src_a = '0;
    src_b = '0;
    hi_in = '0;
    lo_in = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst whilo", 64'(whilo), 64'(0));
    chk("rst whi", 64'(whi), 64'(0));
    chk("rst wlo", 64'(wlo), 64'(0));
    resetn = 1'b1;

    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_wr("mult", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(3'b011, 32'd100, 32'd7);
    wait_wr("divu", 34, 32'd2, 32'd14);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_wr("div neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_wr("div ovf", 34, 32'd0, 32'h8000_0000);
    issue(3'b010, 32'h0000_1234, 32'd0);
    wait_wr("div0", 34, 32'h0000_1234, 32'hFFFF_FFFF);
    issue(3'b001, 32'd7, 32'd9);
    wait_wr("b2b", 2, 32'd0, 32'd63);

    issue(3'b011, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'(0));
    issue(3'b001, 32'd5, 32'd6);
    wait_wr("flush mulu", 2, 32'd0, 32'd30);

    op_valid = 1'b1;
    op = 3'b000;
    src_a = 32'd2;
    src_b = 32'd3;
    flush = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    flush = 1'b0;
    chk("flush req busy", 64'(busy), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("flush req whilo", 64'(whilo), 64'(0));
    end

    issue(3'b011, 32'd9, 32'd2);
    op_valid = 1'b1;
    op = 3'b001;
    src_a = 32'd3;
    src_b = 32'd4;
    wait_wr("hold div", 34, 32'd1, 32'd4);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    wait_wr("hold mul", 2, 32'd0, 32'd12);
    repeat (4) begin
      @(negedge clk);
      chk("hold once", 64'(busy), 64'(0));
    end

    issue(3'b010, 32'd50, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("mid rst busy", 64'(busy), 64'(0));
    chk("mid rst whilo", 64'(whilo), 64'(0));
    chk("mid rst whi", 64'(whi), 64'(0));
    chk("mid rst wlo", 64'(wlo), 64'(0));
    repeat (40) begin
      @(negedge clk);
      chk("mid rst nowr", 64'(whilo), 64'(0));
    end

    hi_in = 32'd0;
    lo_in = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
    issue(3'b101, 32'd1, 32'd1);
    wait_wr("maddu", 2, 32'd1, 32'd0);
    hi_in = 32'd0;
    lo_in = 32'd0;
    issue(3'b110, 32'd2, 32'd3);
    wait_wr("msub", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
`else
    issue(3'b101, 32'd1, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("maddu busy", 64'(busy), 64'(0));
      chk("maddu whilo", 64'(whilo), 64'(0));
    end
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
